bcd_scan_display: RTL and testbench
===================================

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Parameters
REQ-001 SHALL have parameter DIGITS, default 4: number of seven-segment digits, legal range 2..8.
REQ-002 SHALL have parameter BIN_W, default 14: binary input width, legal range 4..27.
REQ-003 SHALL have parameter SCAN_DIV, default 25000: clk cycles per digit scan slot, minimum 2.

Interface
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset; rst=0 resets the block.
REQ-006 SHALL have port bin, input, BIN_W bits: value to display.
REQ-007 SHALL have port load, input, 1 bit: conversion request, sampled only in IDLE.
REQ-008 SHALL have port hex_mode, input, 1 bit: 1 = hexadecimal, 0 = decimal; sampled together with load.
REQ-009 SHALL have port blank_lz, input, 1 bit: 1 = blank leading zeros.
REQ-010 SHALL have port mask, input, DIGITS bits: per-digit enable; bit i=1 enables digit i (digit 0 is rightmost).
REQ-011 SHALL have port dp, input, DIGITS bits: per-digit decimal-point request.
REQ-012 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the display registers update.
REQ-014 SHALL have port ovf, output, 1 bit: the last converted value did not fit in DIGITS digits.
REQ-015 SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-016 SHALL have port dp_on, output, 1 bit: active-high decimal point for the digit being scanned.
REQ-017 SHALL have port an, output, DIGITS bits: active-low one-hot anode select.

Function
REQ-018 SHALL use an FSM with three states, IDLE, CONV and LATCH, with these transitions:
- IDLE→LATCH when load=1 and hex_mode=1.
- IDLE→CONV when load=1 and hex_mode=0.
- CONV→LATCH after exactly BIN_W shift cycles.
- LATCH→IDLE unconditionally.
REQ-019 SHALL, on load in IDLE, capture bin and hex_mode into internal registers; later changes to these inputs SHALL NOT affect the conversion.
REQ-020 SHALL perform the decimal conversion sequentially as double-dabble, one bit per cycle, MSB first:
- on every CONV cycle, add 3 to each BCD nibble that is ≥5, then shift left one bit.
- DIGITS nibbles plus one extra guard nibble are used for overflow detection.
REQ-021 SHALL, in hex mode, take digit i directly from captured bits [4i+3:4i], zero-extended where bin is shorter.
REQ-022 SHALL set ovf in LATCH as follows:
- decimal mode: ovf=1 when the captured value ≥ 10^DIGITS.
- hex mode: ovf=1 when any captured bit at or above position 4*DIGITS is 1.
REQ-023 SHALL, when ovf=1, load every display digit with the dash code (segment g only lit).
REQ-024 SHALL update the display registers and pulse done=1 at the LATCH cycle, with this timing:
- decimal: LATCH occurs BIN_W+1 cycles after the load edge.
- hex: LATCH occurs 1 cycle after the load edge.
REQ-025 SHALL assert busy=1 in CONV and LATCH and 0 in IDLE.
REQ-026 SHALL ignore load while busy=1; such a request is not queued.
REQ-027 SHALL hold the previous display contents unchanged during CONV, so the displayed value never changes mid-conversion.
REQ-028 SHALL encode segments for values 0-F (active-low):
- 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
- 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- dash=7'h3F.
REQ-029 SHALL run a free-running scan prescaler counting 0..SCAN_DIV-1; at each wrap the scan index advances i→(i+1) mod DIGITS.
REQ-030 SHALL drive an[i]=0 only for the current scan index, and only if the digit is not suppressed.
REQ-031 SHALL treat a digit as suppressed when either condition holds:
- mask[i]=0; or
- blank_lz=1, ovf=0, i>0, and digits i..DIGITS-1 are all zero.
REQ-032 SHALL drive seg=7'h7F and dp_on=0 for a suppressed digit; otherwise seg shows the decoded digit and dp_on=dp[index].
REQ-033 SHALL register seg, an and dp_on so that all three change on the same edge (glitch-free).

Reset
REQ-034 SHALL, on rst=0, immediately (asynchronously) force:
- state=IDLE, busy=0, done=0, ovf=0;
- all digits=0, scan index=0, prescaler=0;
- seg=7'h7F, an all ones, dp_on=0.
REQ-035 SHALL abort any conversion in progress on reset, without a done pulse; after release the display shows zeros subject to mask and blanking.

Verification
REQ-036 SHALL cover decimal conversion (DIGITS=4, BIN_W=14): bin=1234, load → done exactly 15 cycles later; digits 1,2,3,4; ovf=0.
REQ-037 SHALL cover overflow: bin=12000, decimal → ovf=1; all enabled digits show 7'h3F.
REQ-038 SHALL cover hex mode with blanking: bin=14'h00AF, hex_mode=1, blank_lz=1 → done after 1 cycle; digits 3,2 dark (an high); digits 1,0 show A, F.
REQ-039 SHALL cover load while busy: a second load at cycle 5 of a conversion is ignored; exactly one done pulse; the first value is displayed.
REQ-040 SHALL cover scan: SCAN_DIV=4 → an cycles 1110, 1101, 1011, 0111, changing every 4 clocks; mask=4'b0101 keeps digits 1 and 3 dark.
REQ-041 SHALL cover reset mid-operation: rst low at cycle 7 of CONV → busy=0, no done pulse, seg=7'h7F, an all ones immediately; after release, displays 0 on digit 0.

Source files
------------

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: converts a binary value to decimal (sequential double-dabble)
// or hexadecimal digits, then drives a time-multiplexed seven-segment display.
// Ports:
//   clk, rst                - clock, asynchronous active-low reset
//   bin, load, hex_mode     - value, conversion request, radix select (captured on load)
//   blank_lz, mask, dp      - live display controls: leading-zero blanking, digit enable, decimal points
//   busy, done, ovf         - conversion status; done pulses when the display digits update
//   seg, dp_on, an          - active-low segments {g..a}, active-high dp, active-low anode select
module bcd_scan_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 25000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  bin,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] mask,
  input  logic [DIGITS-1:0] dp,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic              dp_on,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned NIB    = DIGITS + 1;        // display nibbles plus guard
  localparam int unsigned BCD_W  = 4 * NIB;
  localparam int unsigned DISP_W = 4 * DIGITS;
  localparam int unsigned EXT_W  = BIN_W + DISP_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W);
  localparam int unsigned IDX_W  = $clog2(DIGITS);
  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                hex_q, hex_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                covf_q, covf_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                dp_on_q, dp_on_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_shift;
  logic [EXT_W-1:0]    bin_ext;
  logic                hex_ovf;
  logic [DIGITS-1:0]   lz;
  logic [3:0]          cur_dig;
  logic                sup;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'h40;
      4'h1: seg_of = 7'h79;
      4'h2: seg_of = 7'h24;
      4'h3: seg_of = 7'h30;
      4'h4: seg_of = 7'h19;
      4'h5: seg_of = 7'h12;
      4'h6: seg_of = 7'h02;
      4'h7: seg_of = 7'h78;
      4'h8: seg_of = 7'h00;
      4'h9: seg_of = 7'h10;
      4'hA: seg_of = 7'h08;
      4'hB: seg_of = 7'h03;
      4'hC: seg_of = 7'h46;
      4'hD: seg_of = 7'h21;
      4'hE: seg_of = 7'h06;
      default: seg_of = 7'h0E;
    endcase
  endfunction

  // Double-dabble adjust: +3 on every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign bin_ext   = EXT_W'(bin_q);
  assign hex_ovf   = |(bin_ext >> DISP_W);

  // Conversion FSM and display digit registers.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    hex_d   = hex_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    covf_d  = covf_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = bin;
          hex_d   = hex_mode;
          cnt_d   = '0;
          bcd_d   = '0;
          covf_d  = 1'b0;
          state_d = hex_mode ? LATCH : CONV;
        end
      end
      CONV: begin
        bcd_d  = bcd_shift;
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        // Partial values only grow, so any guard activity means the final value overflows.
        covf_d = covf_q | bcd_adj[BCD_W-1] | (bcd_shift[BCD_W-1 -: 4] != 4'd0);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = LATCH;
      end
      LATCH: begin
        disp_d  = hex_q ? bin_ext[DISP_W-1:0] : bcd_q[DISP_W-1:0];
        ovf_d   = hex_q ? hex_ovf : covf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Scan prescaler, digit select and suppression.
  always_comb begin
    pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    idx_d   = idx_q;
    if (pre_q == PRE_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    lz = '0;
    lz[DIGITS-1] = (disp_q[DISP_W-1 -: 4] == 4'd0);
    for (int unsigned k = 1; k < DIGITS; k++) begin
      lz[DIGITS-1-k] = lz[DIGITS-k] & (disp_q[4*(DIGITS-1-k) +: 4] == 4'd0);
    end

    cur_dig = disp_q[4*idx_q +: 4];
    sup     = ~mask[idx_q] | (blank_lz & ~ovf_q & (idx_q != '0) & lz[idx_q]);

    seg_d   = 7'h7F;
    an_d    = '1;
    dp_on_d = 1'b0;
    if (!sup) begin
      seg_d   = ovf_q ? 7'h3F : seg_of(cur_dig);
      an_d    = ~(DIGITS'(1) << idx_q);
      dp_on_d = dp[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      hex_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      covf_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      dp_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      hex_q   <= hex_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      covf_q  <= covf_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_on_q <= dp_on_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign dp_on = dp_on_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (DIGITS=4, BIN_W=14, SCAN_DIV=4):
// a table of load vectors with hand-computed display results, plus directed
// sequences for load-while-busy, scan order and reset during conversion.
module tb_bcd_scan_display;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned BIN_W    = 14;
  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin;
  logic        load, hex_mode, blank_lz;
  logic [3:0]  mask, dp;
  logic        busy, done, ovf, dp_on;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_scan_display #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .bin(bin), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .mask(mask), .dp(dp), .busy(busy), .done(done),
    .ovf(ovf), .seg(seg), .dp_on(dp_on), .an(an)
  );

  typedef struct {
    logic [13:0]     bin;
    logic            hex;
    logic            blank;
    logic [3:0]      mask;
    logic [3:0]      dp;
    logic            ovf;
    int              lat;
    logic [3:0][6:0] segs;   // expected segments, digit 3 .. digit 0
    logic [3:0]      dark;   // digits expected never to be selected
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [13:0] b, input logic h, input logic bl,
                              input logic [3:0] m, input logic [3:0] d, input logic o,
                              input int l, input logic [27:0] s, input logic [3:0] dk);
    vec_t v;
    v.bin = b; v.hex = h; v.blank = bl; v.mask = m; v.dp = d;
    v.ovf = o; v.lat = l; v.segs = s; v.dark = dk;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Issue one load and wait (bounded) for done; inputs are scrambled after capture.
  task automatic do_load(input logic [13:0] b, input logic h, output int lat,
                         output logic bsy_start, output logic bsy_end, output logic ovf_end);
    @(negedge clk);
    bin = b; hex_mode = h; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; bsy_start = busy; bin = ~b; hex_mode = ~h;
    lat = -1; bsy_end = 1'b1; ovf_end = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; bsy_end = busy; ovf_end = ovf;
        break;
      end
    end
  endtask

  // Observe one full scan period (16 clocks) and check every slot.
  task automatic check_display(input string nm, input logic [3:0][6:0] es,
                               input logic [3:0] dark, input logic [3:0] dpv);
    int cnt[4];
    int bad[4];
    int idle_bad;
    logic [3:0] a;
    logic hit;
    idle_bad = 0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; bad[i] = 0; end
    for (int s = 0; s < 16; s++) begin
      @(posedge clk); #1;
      a = an;
      if (a == 4'hF) begin
        if (seg != 7'h7F || dp_on != 1'b0) idle_bad++;
      end else begin
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (a == ~(4'b0001 << i)) begin
            hit = 1'b1;
            cnt[i]++;
            if (seg != es[i] || dp_on != dpv[i]) bad[i]++;
          end
        end
        if (!hit) idle_bad++;
      end
    end
    check($sformatf("%s dark-slot/onehot errors", nm), idle_bad, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s digit%0d select count", nm, i), cnt[i], dark[i] ? 0 : 4);
      if (!dark[i]) check($sformatf("%s digit%0d seg/dp errors", nm, i), bad[i], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, ndone, first_done, hold_bad, found, scan_bad;
    logic bs, be, oe;
    logic [3:0] prev_an;
    logic [3:0] exp_an[4];

    vecs[0]  = mk(14'd1234,  1'b0, 1'b0, 4'hF, 4'b0000, 1'b0, 15, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
    vecs[1]  = mk(14'd12000, 1'b0, 1'b0, 4'hF, 4'b0000, 1'b1, 15, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
    vecs[2]  = mk(14'h00AF,  1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 1,  {7'h7F, 7'h7F, 7'h08, 7'h0E}, 4'b1100);
    vecs[3]  = mk(14'd9999,  1'b0, 1'b0, 4'hF, 4'b0100, 1'b0, 15, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b0000);
    vecs[4]  = mk(14'd10000, 1'b0, 1'b1, 4'hF, 4'b0000, 1'b1, 15, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
    vecs[5]  = mk(14'd0,     1'b0, 1'b1, 4'hF, 4'b0001, 1'b0, 15, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110);
    vecs[6]  = mk(14'h3FFF,  1'b1, 1'b0, 4'hF, 4'b1000, 1'b0, 1,  {7'h30, 7'h0E, 7'h0E, 7'h0E}, 4'b0000);
    vecs[7]  = mk(14'd1234,  1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0, 15, {7'h7F, 7'h24, 7'h7F, 7'h19}, 4'b1010);
    vecs[8]  = mk(14'd7,     1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 15, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1110);
    vecs[9]  = mk(14'h0506,  1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 1,  {7'h7F, 7'h12, 7'h40, 7'h02}, 4'b1000);
    vecs[10] = mk(14'd305,   1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 15, {7'h7F, 7'h30, 7'h40, 7'h12}, 4'b1000);
    vecs[11] = mk(14'h1DE8,  1'b1, 1'b0, 4'hF, 4'b0000, 1'b0, 1,  {7'h79, 7'h21, 7'h06, 7'h00}, 4'b0000);
    vecs[12] = mk(14'h0B0C,  1'b1, 1'b0, 4'hF, 4'b0000, 1'b0, 1,  {7'h40, 7'h03, 7'h40, 7'h46}, 4'b0000);

    exp_an[0] = 4'hE; exp_an[1] = 4'hD; exp_an[2] = 4'hB; exp_an[3] = 4'h7;

    // Asynchronous reset with no clock edge in between.
    rst = 1'b1; load = 1'b0; bin = '0; hex_mode = 1'b0;
    blank_lz = 1'b0; mask = 4'hF; dp = 4'h0;
    #2 rst = 1'b0;
    #1;
    check("reset seg",   int'(seg),   7'h7F);
    check("reset an",    int'(an),    4'hF);
    check("reset dp_on", int'(dp_on), 0);
    check("reset busy",  int'(busy),  0);
    check("reset done",  int'(done),  0);
    check("reset ovf",   int'(ovf),   0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Table-driven conversions.
    for (int k = 0; k < 13; k++) begin
      blank_lz = vecs[k].blank; mask = vecs[k].mask; dp = vecs[k].dp;
      do_load(vecs[k].bin, vecs[k].hex, lat, bs, be, oe);
      check($sformatf("v%0d done latency", k), lat, vecs[k].lat);
      check($sformatf("v%0d busy after load", k), int'(bs), 1);
      check($sformatf("v%0d busy at done", k), int'(be), 0);
      check($sformatf("v%0d ovf", k), int'(oe), int'(vecs[k].ovf));
      @(posedge clk); #1;
      check($sformatf("v%0d done one cycle", k), int'(done), 0);
      check_display($sformatf("v%0d", k), vecs[k].segs, vecs[k].dark, vecs[k].dp);
    end

    // Load while busy is ignored; display holds during conversion.
    blank_lz = 1'b0; mask = 4'hF; dp = 4'h0;
    do_load(14'd9999, 1'b0, lat, bs, be, oe);
    check("pre-busy load latency", lat, 15);
    @(negedge clk);
    bin = 14'd1234; hex_mode = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; bin = 14'd567;
    ndone = 0; first_done = -1; hold_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      if (n <= 14 && an != 4'hF && seg != 7'h10) hold_bad++;
      if (n == 4) load = 1'b1;
      if (n == 5) load = 1'b0;
    end
    check("busy-load done pulses", ndone, 1);
    check("busy-load done latency", first_done, 15);
    check("display hold during conv", hold_bad, 0);
    check_display("busy-load", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, 4'b0000);

    // Scan order: an steps E, D, B, 7, four clocks each.
    found = 0;
    @(posedge clk); #1;
    prev_an = an;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (an == 4'hE && prev_an != 4'hE) begin found = 1; break; end
      prev_an = an;
    end
    check("scan align found", found, 1);
    scan_bad = 0;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      if (an != exp_an[k/4]) scan_bad++;
    end
    check("scan order errors", scan_bad, 0);

    // Reset during conversion: immediate blank, no done, zeros afterwards.
    blank_lz = 1'b1;
    @(negedge clk);
    bin = 14'd4321; hex_mode = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid-conv reset busy", int'(busy), 0);
    check("mid-conv reset done", int'(done), 0);
    check("mid-conv reset seg",  int'(seg),  7'h7F);
    check("mid-conv reset an",   int'(an),   4'hF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("post-reset done/busy activity", ndone, 0);
    check_display("post-reset", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
